// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues valid/ack memory requests
// and buffers fetched words with their PCs and fault flags in a prefetch FIFO.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_inc,
  input  logic        pc_load,
  input  logic [31:0] pc_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        imem_fault,
  output logic [31:0] instruction,
  output logic        wait_instr,
  output logic        instr_segv,
  output logic [31:0] pc
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [31:0] word;
    logic        fault;
    logic [31:0] pc;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [31:0]     fetch_pc;
  logic            halted;
  logic            empty;
  logic            push;
  logic            pop;
  entry_t          head;

  assign empty     = (count == '0);
  assign imem_req  = !rst && !halted && (count < CW'(DEPTH));
  assign imem_addr = fetch_pc;
  assign push      = imem_req && imem_ack && !pc_load;
  assign pop       = pc_inc && !empty && !pc_load;

  // Redirect flushes everything; a misaligned target becomes a single faulted entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      halted   <= 1'b0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else if (pc_load) begin
      fetch_pc <= pc_target;
      rd_ptr   <= '0;
      if (pc_target[1:0] != 2'b00) begin
        mem[0]  <= '{word: 32'h0, fault: 1'b1, pc: pc_target};
        wr_ptr  <= AW'(1);
        count   <= CW'(1);
        halted  <= 1'b1;
      end else begin
        wr_ptr  <= '0;
        count   <= '0;
        halted  <= 1'b0;
      end
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (imem_fault) begin
          mem[wr_ptr] <= '{word: 32'h0, fault: 1'b1, pc: fetch_pc};
          halted      <= 1'b1;
        end else begin
          mem[wr_ptr] <= '{word: imem_rdata, fault: 1'b0, pc: fetch_pc};
          fetch_pc    <= fetch_pc + 32'd4;
        end
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head        = mem[rd_ptr];
  assign wait_instr  = empty;
  assign instruction = empty ? 32'h0 : head.word;
  assign instr_segv  = !empty && head.fault;
  assign pc          = empty ? fetch_pc : head.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch; memory returns addr+0x100.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst, pc_inc, pc_load, imem_ack, imem_fault;
  logic [31:0] pc_target, imem_addr, imem_rdata, instruction, pc;
  logic        imem_req, wait_instr, instr_segv;
  int          nvec = 0;
  int          nmis = 0;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr + 32'h100;

  instr_fetch #(.RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .pc_inc(pc_inc), .pc_load(pc_load),
    .pc_target(pc_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .imem_fault(imem_fault),
    .instruction(instruction), .wait_instr(wait_instr),
    .instr_segv(instr_segv), .pc(pc)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [31:0] epc,
                          input logic [31:0] einstr, input logic esegv,
                          input logic ewait);
    chk({tag, ".pc"}, pc, epc);
    chk({tag, ".instr"}, instruction, einstr);
    chk({tag, ".segv"}, 32'(instr_segv), 32'(esegv));
    chk({tag, ".wait"}, 32'(wait_instr), 32'(ewait));
  endtask

  initial begin
    rst = 1'b1; pc_inc = 1'b0; pc_load = 1'b0; pc_target = 32'h0;
    imem_ack = 1'b0; imem_fault = 1'b0;
    step(); step();
    chk("rst.req", 32'(imem_req), 32'd0);
    chk_head("rst", 32'h0, 32'h0, 1'b0, 1'b1);

    // streaming: ack and pop every cycle
    rst = 1'b0; imem_ack = 1'b1; pc_inc = 1'b1;
    #1;
    chk("s.req0", 32'(imem_req), 32'd1);
    chk("s.addr0", imem_addr, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk_head("stream", 32'(i * 4), 32'h100 + 32'(i * 4), 1'b0, 1'b0);
      chk("stream.req", 32'(imem_req), 32'd1);
    end

    // fill without popping
    rst = 1'b1; pc_inc = 1'b0;
    step();
    rst = 1'b0;
    #1;
    chk("f.addr0", imem_addr, 32'h0);
    step();
    chk("f.addr1", imem_addr, 32'h4);
    chk("f.req1", 32'(imem_req), 32'd1);
    step();
    chk("full.req", 32'(imem_req), 32'd0);
    chk("full.addr", imem_addr, 32'h8);
    chk_head("full", 32'h0, 32'h100, 1'b0, 1'b0);
    step();
    chk("full2.req", 32'(imem_req), 32'd0);
    chk_head("full2", 32'h0, 32'h100, 1'b0, 1'b0);
    pc_inc = 1'b1;
    step();
    pc_inc = 1'b0;
    chk("pop.req", 32'(imem_req), 32'd1);
    chk("pop.addr", imem_addr, 32'h8);
    chk_head("pop", 32'h4, 32'h104, 1'b0, 1'b0);

    // memory stall with draining FIFO
    imem_ack = 1'b0; pc_inc = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall.req", 32'(imem_req), 32'd1);
      chk("stall.addr", imem_addr, 32'h8);
      chk_head("stall", 32'h8, 32'h0, 1'b0, 1'b1);
    end

    // redirect during a transfer discards the data
    pc_inc = 1'b0; imem_ack = 1'b1;
    step();
    chk_head("pre_ld", 32'h8, 32'h108, 1'b0, 1'b0);
    pc_load = 1'b1; pc_target = 32'h40;
    step();
    pc_load = 1'b0; imem_ack = 1'b0;
    chk_head("ld40", 32'h40, 32'h0, 1'b0, 1'b1);
    chk("ld40.addr", imem_addr, 32'h40);
    chk("ld40.req", 32'(imem_req), 32'd1);
    step();
    chk_head("ld40.idle", 32'h40, 32'h0, 1'b0, 1'b1);
    imem_ack = 1'b1;
    step();
    chk_head("ld40.first", 32'h40, 32'h140, 1'b0, 1'b0);

    // memory fault at 0xC halts fetch
    imem_ack = 1'b0; pc_load = 1'b1; pc_target = 32'hC;
    step();
    pc_load = 1'b0; imem_ack = 1'b1; imem_fault = 1'b1;
    step();
    imem_fault = 1'b0;
    chk_head("flt", 32'hC, 32'h0, 1'b1, 1'b0);
    chk("flt.req", 32'(imem_req), 32'd0);
    step();
    chk_head("flt.hold", 32'hC, 32'h0, 1'b1, 1'b0);
    chk("flt.hold.req", 32'(imem_req), 32'd0);
    pc_load = 1'b1; pc_target = 32'h80;
    step();
    pc_load = 1'b0;
    chk_head("ld80", 32'h80, 32'h0, 1'b0, 1'b1);
    chk("ld80.addr", imem_addr, 32'h80);
    chk("ld80.req", 32'(imem_req), 32'd1);
    step();
    chk_head("ld80.first", 32'h80, 32'h180, 1'b0, 1'b0);

    // misaligned redirect with a same-cycle pop
    pc_load = 1'b1; pc_target = 32'h42; pc_inc = 1'b1;
    step();
    pc_load = 1'b0; pc_inc = 1'b0;
    chk_head("mis", 32'h42, 32'h0, 1'b1, 1'b0);
    chk("mis.req", 32'(imem_req), 32'd0);
    pc_inc = 1'b1;
    step();
    pc_inc = 1'b0;
    chk_head("mis.pop", 32'h42, 32'h0, 1'b0, 1'b1);
    chk("mis.pop.req", 32'(imem_req), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_head("rst2", 32'h0, 32'h0, 1'b0, 1'b1);
    #1;
    chk("rst2.req", 32'(imem_req), 32'd1);

    // fetch PC wraps past the top of the address space
    pc_load = 1'b1; pc_target = 32'hFFFF_FFFC;
    step();
    pc_load = 1'b0;
    step();
    chk_head("wrap", 32'hFFFF_FFFC, 32'h0000_00FC, 1'b0, 1'b0);
    chk("wrap.addr", imem_addr, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
